// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, branch flush and memory-wait freeze.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipeline_hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned MEM_TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        idex_memread,
   input  logic [4:0]  idex_rt,
   input  logic [4:0]  ifid_rs,
   input  logic [4:0]  ifid_rt,
   input  logic        ifid_uses_rt,
   input  logic        branch_taken,
   input  logic        mem_busy,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        ifid_flush,
   output logic        idex_write,
   output logic        idex_bubble,
   output logic        mem_timeout,
   output logic [1:0]  state,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MWAIT   = 2'd1,
      FLUSH   = 2'd2,
      ILLEGAL = 2'd3
   } state_t;

   localparam logic [3:0] FLUSH_INIT  = 4'(FLUSH_CYCLES - 1);
   localparam logic [7:0] TIMEOUT_V   = 8'(MEM_TIMEOUT);
   localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

   state_t     st;
   logic [7:0] wait_cnt;
   logic [7:0] wait_nxt;
   logic [3:0] flush_left;
   logic       load_use;
   logic       take_branch;
   logic       take_stall;

   assign state = st;

   assign load_use = idex_memread & (idex_rt != 5'd0) &
                     ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

   // Entering a wait from RUN/FLUSH counts as the first wait cycle.
   assign wait_nxt = (st != MWAIT)       ? 8'd1 :
                     (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;

   always_comb begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_write  = 1'b0;
      idex_bubble = 1'b0;
      take_branch = 1'b0;
      take_stall  = 1'b0;
      if (reset_n && !mem_busy) begin
         case (st)
            RUN, MWAIT: begin
               if (branch_taken) begin
                  pc_write    = 1'b1;
                  ifid_write  = 1'b1;
                  idex_write  = 1'b1;
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
                  take_branch = 1'b1;
               end else if (load_use) begin
                  idex_write  = 1'b1;
                  idex_bubble = 1'b1;
                  take_stall  = 1'b1;
               end else begin
                  pc_write   = 1'b1;
                  ifid_write = 1'b1;
                  idex_write = 1'b1;
               end
            end
            FLUSH: begin
               pc_write    = 1'b1;
               ifid_write  = 1'b1;
               idex_write  = 1'b1;
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st          <= RUN;
         wait_cnt    <= '0;
         flush_left  <= '0;
         mem_timeout <= 1'b0;
      end else if (st == ILLEGAL) begin
         st         <= RUN;
         wait_cnt   <= '0;
         flush_left <= '0;
      end else if (mem_busy) begin
         st         <= MWAIT;
         wait_cnt   <= wait_nxt;
         flush_left <= '0;
         if (wait_nxt == TIMEOUT_V)
            mem_timeout <= 1'b1;
      end else begin
         wait_cnt <= '0;
         if (st == FLUSH) begin
            if (flush_left <= 4'd1) begin
               st         <= RUN;
               flush_left <= '0;
            end else begin
               flush_left <= flush_left - 4'd1;
            end
         end else if (take_branch) begin
            st         <= MULTI_FLUSH ? FLUSH : RUN;
            flush_left <= FLUSH_INIT;
         end else begin
            st <= RUN;
         end
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [15:0] stall_q;
   logic [15:0] flush_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (take_stall && stall_q != '1)
            stall_q <= stall_q + 16'd1;
         if (take_branch && flush_q != '1)
            flush_q <= flush_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   logic unused_perf;
   assign unused_perf = take_stall;
   assign stall_cnt   = '0;
   assign flush_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (FLUSH_CYCLES=3, MEM_TIMEOUT=5).
module tb_pipeline_hazard_ctrl;

   localparam int unsigned FC = 3;
   localparam int unsigned MT = 5;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        idex_memread = 1'b0;
   logic [4:0]  idex_rt = '0;
   logic [4:0]  ifid_rs = '0;
   logic [4:0]  ifid_rt = '0;
   logic        ifid_uses_rt = 1'b0;
   logic        branch_taken = 1'b0;
   logic        mem_busy = 1'b0;
   logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, mem_timeout;
   logic [1:0]  state;
   logic [15:0] stall_cnt, flush_cnt;

   pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
      .clk(clk), .reset_n(reset_n),
      .idex_memread(idex_memread), .idex_rt(idex_rt),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
      .branch_taken(branch_taken), .mem_busy(mem_busy),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_write(idex_write), .idex_bubble(idex_bubble),
      .mem_timeout(mem_timeout), .state(state),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  en;   // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble}
      logic [1:0]  st;
      logic        to;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   exp_t q[$];
   int unsigned n_checks = 0;
   int unsigned n_fail = 0;

   int          m_state = 0;
   int unsigned m_wait = 0, m_fleft = 0, m_stall = 0, m_flush = 0;
   logic        m_tout = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic hazard();
      return idex_memread && (idex_rt != 5'd0) &&
             ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
   endfunction

   function automatic exp_t predict();
      exp_t e;
      e.en = 5'b00000;
      if (reset_n && !mem_busy) begin
         if (m_state == 2 || branch_taken) e.en = 5'b11111;
         else if (hazard())                e.en = 5'b00011;
         else                              e.en = 5'b11010;
      end
      e.st = 2'(m_state);
      e.to = m_tout;
`ifdef PIPE_CTRL_PERF_EN
      e.sc = 16'(m_stall);
      e.fc = 16'(m_flush);
`else
      e.sc = 16'h0000;
      e.fc = 16'h0000;
`endif
      return e;
   endfunction

   task automatic model_reset();
      m_state = 0; m_wait = 0; m_fleft = 0; m_stall = 0; m_flush = 0; m_tout = 1'b0;
   endtask

   task automatic advance();
      if (mem_busy) begin
         if (m_state == 1) m_wait = (m_wait < 255) ? m_wait + 1 : 255;
         else              m_wait = 1;
         if (m_wait == MT) m_tout = 1'b1;
         m_state = 1;
         m_fleft = 0;
      end else if (m_state == 2) begin
         m_fleft = m_fleft - 1;
         m_wait  = 0;
         if (m_fleft == 0) m_state = 0;
      end else if (branch_taken) begin
         if (m_flush < 65535) m_flush++;
         m_fleft = FC - 1;
         m_state = (FC > 1) ? 2 : 0;
         m_wait  = 0;
      end else begin
         if (hazard() && m_stall < 65535) m_stall++;
         m_state = 0;
         m_wait  = 0;
      end
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (q.size() == 0) begin
         check({tag, "/sb_empty"}, 32'd1, 32'd0);
         return;
      end
      e = q.pop_front();
      check({tag, "/en"}, 32'({pc_write, ifid_write, ifid_flush, idex_write, idex_bubble}), 32'(e.en));
      check({tag, "/state"}, 32'(state), 32'(e.st));
      check({tag, "/timeout"}, 32'(mem_timeout), 32'(e.to));
      check({tag, "/stall_cnt"}, 32'(stall_cnt), 32'(e.sc));
      check({tag, "/flush_cnt"}, 32'(flush_cnt), 32'(e.fc));
   endtask

   task automatic cycle(input string tag, input logic mr, input logic [4:0] xrt,
                        input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                        input logic br, input logic busy);
      idex_memread = mr; idex_rt = xrt; ifid_rs = rs; ifid_rt = rt;
      ifid_uses_rt = ur; branch_taken = br; mem_busy = busy;
      q.push_back(predict());
      @(negedge clk);
      pop_check(tag);
      @(posedge clk);
      if (reset_n) advance();
      #1;
   endtask

   task automatic idle(input string tag);
      cycle(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      cycle("rst_hold", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      cycle("rst_hold_lu", 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
      idle("run_idle");

      cycle("lu_rs", 1'b1, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0, 1'b0);
      idle("after_lu");
      cycle("lu_rt", 1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0);
      cycle("rt_unused", 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0);
      cycle("zero_reg", 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      cycle("no_memread", 1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0);

      cycle("br_det", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      idle("flush2"); idle("flush3"); idle("post_flush");

      cycle("br_and_lu", 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0);
      cycle("flush_ign_br", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      idle("flush_end"); idle("post_flush2");

      for (int i = 0; i < 4; i++) cycle("mwait", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      idle("mwait_exit"); idle("after_mwait");

      cycle("busy_br", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      cycle("busy_br2", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      cycle("br_after_wait", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      cycle("flush_busy", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      idle("wait_no_resid"); idle("no_resid2");

      for (int i = 0; i < 10; i++) cycle("timeout", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      idle("tout_sticky"); idle("tout_sticky2");

      cycle("br_pre_rst", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      #1;
      reset_n = 1'b0;
      model_reset();
      q.push_back(predict());
      #1;
      pop_check("async_rst");
      idle("rst_low");
      reset_n = 1'b1;
      idle("post_rst1"); idle("post_rst2"); idle("post_rst3");

      for (int i = 0; i < 60; i++)
         cycle("rand", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 7) == 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
